// File: rtl/pipeline_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer_pkg
// Constants used by the pipeline stall/flush sequencer and the pipeline
// registers it controls.
//   ST_RUN / ST_MEM_WAIT / ST_MD_WAIT : sequencer state encodings (2 bits)
//   NOP_INSTR                         : instruction loaded by flush/bubble muxes
//   MD_CNT_W                          : width of the mult/div occupancy counter
// ---------------------------------------------------------------------------
package pipeline_sequencer_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MD_WAIT  = 2'd2;

    // sll $0,$0,0 -- the canonical MIPS NOP.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Wide enough for the largest legal mult/div latency (255).
    localparam int MD_CNT_W = 8;

endpackage

// File: rtl/pipeline_sequencer_sat.sv
// ---------------------------------------------------------------------------
// sat_counter
// Width-parameterised saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   clear : synchronous clear to 0 (has priority over inc)
//   inc   : add one this cycle unless already at all-ones
//   count : current count value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges hazard
// unit requests, imem/dmem waits and mult/div occupancy into per-stage
// register enables, bubble inserts and the IF/ID flush.
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   hz_stall     : load-use stall request
//   hz_flush     : taken branch/jump
//   imem_ready   : instruction memory data valid
//   dmem_req     : MEM stage accesses data memory
//   dmem_ready   : data memory completes this cycle
//   md_start     : EX holds a mult/div (held while it stays in EX)
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en : register enables
//   ifid_flush, idex_bubble, exmem_bubble       : NOP inserts
//   md_done      : one-cycle pulse, mult/div result valid in EX
//   state        : 0=RUN, 1=MEM_WAIT, 2=MD_WAIT
//   stall_count  : saturating count of cycles with pc_en=0
// ---------------------------------------------------------------------------
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall,
    input  logic             hz_flush,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             md_start,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             exmem_bubble,
    output logic             memwb_en,
    output logic             md_done,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    // The entry cycle counts as the first EX cycle, so the counter is loaded
    // with the cycles still to go; the cycle that would take it from 1 to 0
    // is the last occupancy cycle and produces md_done.
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

    logic [1:0]          state_next;
    logic [MD_CNT_W-1:0] md_cnt;
    logic [MD_CNT_W-1:0] md_cnt_next;
    logic                dmem_stall;
    logic                eval_rules;
    logic                allow_md;

    assign dmem_stall = dmem_req & ~dmem_ready;

    // Each state either forces its own outputs or hands over to the shared
    // priority chain (R2..R6, or R3..R6 when a mult/div is just finishing).
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        exmem_bubble = 1'b0;
        memwb_en     = 1'b1;
        md_done      = 1'b0;
        state_next   = ST_RUN;
        md_cnt_next  = md_cnt;
        eval_rules   = 1'b0;
        allow_md     = 1'b0;

        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            md_cnt_next  = '0;
        end else begin
            case (state)
                ST_MEM_WAIT: begin
                    if (!dmem_ready) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_en    = 1'b0;
                        exmem_en   = 1'b0;
                        memwb_en   = 1'b0;
                        state_next = ST_MEM_WAIT;
                    end else begin
                        eval_rules = 1'b1;
                        allow_md   = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    if (dmem_stall) begin
                        // Freeze everything; the occupancy counter holds.
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_en    = 1'b0;
                        exmem_en   = 1'b0;
                        memwb_en   = 1'b0;
                        state_next = ST_MD_WAIT;
                    end else if (md_cnt > MD_CNT_W'(1)) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_bubble = 1'b1;
                        md_cnt_next  = md_cnt - MD_CNT_W'(1);
                        state_next   = ST_MD_WAIT;
                    end else begin
                        // Final occupancy cycle: result valid, md_start ignored.
                        md_done     = 1'b1;
                        md_cnt_next = '0;
                        eval_rules  = 1'b1;
                    end
                end
                default: begin
                    // RUN, and the unreachable encoding 3 treated as RUN.
                    if (dmem_stall) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_en    = 1'b0;
                        exmem_en   = 1'b0;
                        memwb_en   = 1'b0;
                        state_next = ST_MEM_WAIT;
                    end else begin
                        eval_rules = 1'b1;
                        allow_md   = 1'b1;
                    end
                end
            endcase

            // Shared priority chain; hz_stall beats hz_flush so the branch
            // re-resolves once the load-use stall clears.
            if (eval_rules) begin
                if (allow_md && md_start) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_bubble = 1'b1;
                    md_cnt_next  = MD_LOAD;
                    state_next   = ST_MD_WAIT;
                end else if (hz_stall) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (hz_flush) begin
                    ifid_flush = 1'b1;
                end else if (!imem_ready) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
        end
    end

    // State and occupancy counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // Reset clear wins over the pc_en=0 increment during reset.
    sat_counter #(
        .W(CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .clear (rst),
        .inc   (~pc_en),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pipeline_sequencer
// Self-checking bench for pipeline_sequencer (MD_LATENCY=4, CNT_W=3).
// Inputs are driven 1 time unit after each rising edge; the expected output
// vector, state and stall count for that cycle are pushed to a scoreboard
// queue and compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_sequencer;

    localparam int MD_LAT = 4;
    localparam int CW     = 3;

    // Output vector order: pc, ifid, ifid_flush, idex, idex_bubble,
    //                      exmem, exmem_bubble, memwb, md_done
    localparam logic [8:0] O_RST   = 9'b0_0_1_0_1_0_1_0_0;
    localparam logic [8:0] O_DEF   = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] O_FRZ   = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] O_STALL = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] O_FLUSH = 9'b1_1_1_1_0_1_0_1_0;
    localparam logic [8:0] O_IMEM  = 9'b0_1_1_1_0_1_0_1_0;
    localparam logic [8:0] O_MD    = 9'b0_0_0_0_0_1_1_1_0;
    localparam logic [8:0] O_DONE  = 9'b1_1_0_1_0_1_0_1_1;
    localparam logic [8:0] O_DNSTL = 9'b0_0_0_1_1_1_0_1_1;

    // Input vector order: rst, hz_stall, hz_flush, imem_ready,
    //                     dmem_req, dmem_ready, md_start
    localparam logic [6:0] I_IDLE  = 7'b0_0_0_1_0_1_0;
    localparam logic [6:0] I_MD    = 7'b0_0_0_1_0_1_1;
    localparam logic [6:0] I_MDDW  = 7'b0_0_0_1_1_0_1;
    localparam logic [6:0] I_DWAIT = 7'b0_0_0_1_1_0_0;
    localparam logic [6:0] I_STALL = 7'b0_1_0_1_0_1_0;

    typedef struct {
        int         idx;
        logic [8:0] outs;
        logic [1:0] st;
        logic [2:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, hz_stall, hz_flush, imem_ready;
    logic          dmem_req, dmem_ready, md_start;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic          exmem_en, exmem_bubble, memwb_en, md_done;
    logic [1:0]    state;
    logic [CW-1:0] stall_count;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [2:0]    model_cnt = 3'd0;

    always #5 clk = ~clk;

    pipeline_sequencer #(
        .MD_LATENCY(MD_LAT),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hz_stall    (hz_stall),
        .hz_flush    (hz_flush),
        .imem_ready  (imem_ready),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .md_start    (md_start),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_en     (idex_en),
        .idex_bubble (idex_bubble),
        .exmem_en    (exmem_en),
        .exmem_bubble(exmem_bubble),
        .memwb_en    (memwb_en),
        .md_done     (md_done),
        .state       (state),
        .stall_count (stall_count)
    );

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic driveInputs(input logic [6:0] in);
        {rst, hz_stall, hz_flush, imem_ready, dmem_req, dmem_ready, md_start} = in;
    endtask

    // Drive one cycle of stimulus and queue the expected result; the stall
    // count model advances from the expected pc_en, not from the DUT.
    task automatic applyStimulus(input logic [6:0] in, input logic [8:0] outs,
                                 input logic [1:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        driveInputs(in);
        e.idx  = cyc;
        e.outs = outs;
        e.st   = st;
        e.cnt  = model_cnt;
        sb.push_back(e);
        cyc++;
        if (in[6]) model_cnt = 3'd0;
        else if (!outs[8] && model_cnt != 3'd7) model_cnt = model_cnt + 3'd1;
    endtask

    // Scoreboard consumer: compare mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput($sformatf("cyc%0d.outs", e.idx),
                        {23'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
                         exmem_en, exmem_bubble, memwb_en, md_done},
                        {23'd0, e.outs});
            checkOutput($sformatf("cyc%0d.state", e.idx), {30'd0, state}, {30'd0, e.st});
            checkOutput($sformatf("cyc%0d.count", e.idx), {29'd0, stall_count}, {29'd0, e.cnt});
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        driveInputs(7'b1111111);
        // Unchecked first reset edge brings state/counters out of X.
        @(posedge clk);
        #1;

        // 1: reset with all inputs high, then release
        applyStimulus(7'b1111111, O_RST, 2'd0);
        applyStimulus(7'b1111111, O_RST, 2'd0);
        applyStimulus(I_IDLE, O_DEF, 2'd0);

        // 2: single load-use stall, then stall together with flush
        applyStimulus(I_STALL, O_STALL, 2'd0);
        applyStimulus(I_IDLE, O_DEF, 2'd0);
        applyStimulus(7'b0_1_1_1_0_1_0, O_STALL, 2'd0);
        applyStimulus(I_IDLE, O_DEF, 2'd0);

        // 3a: mult/div with md_start held, done on the fourth EX cycle
        applyStimulus(I_MD, O_MD, 2'd0);
        applyStimulus(I_MD, O_MD, 2'd2);
        applyStimulus(I_MD, O_MD, 2'd2);
        applyStimulus(I_MD, O_DONE, 2'd2);
        applyStimulus(I_IDLE, O_DEF, 2'd0);

        // 3b: two-cycle dmem stall inside MD_WAIT delays md_done by two
        applyStimulus(I_MD, O_MD, 2'd0);
        applyStimulus(I_MDDW, O_FRZ, 2'd2);
        applyStimulus(I_MDDW, O_FRZ, 2'd2);
        applyStimulus(I_MD, O_MD, 2'd2);
        applyStimulus(I_MD, O_MD, 2'd2);
        applyStimulus(I_MD, O_DONE, 2'd2);
        applyStimulus(I_IDLE, O_DEF, 2'd0);

        // 3c: load-use stall on the done cycle still reports md_done
        applyStimulus(I_MD, O_MD, 2'd0);
        applyStimulus(I_MD, O_MD, 2'd2);
        applyStimulus(I_MD, O_MD, 2'd2);
        applyStimulus(7'b0_1_0_1_0_1_1, O_DNSTL, 2'd2);
        applyStimulus(I_IDLE, O_DEF, 2'd0);

        // 4a: three-cycle dmem wait, then release
        applyStimulus(I_DWAIT, O_FRZ, 2'd0);
        applyStimulus(I_DWAIT, O_FRZ, 2'd1);
        applyStimulus(I_DWAIT, O_FRZ, 2'd1);
        applyStimulus(7'b0_0_0_1_1_1_0, O_DEF, 2'd1);
        applyStimulus(I_IDLE, O_DEF, 2'd0);

        // 4b: md_start on the release cycle enters MD_WAIT
        applyStimulus(I_DWAIT, O_FRZ, 2'd0);
        applyStimulus(I_DWAIT, O_FRZ, 2'd1);
        applyStimulus(I_DWAIT, O_FRZ, 2'd1);
        applyStimulus(7'b0_0_0_1_1_1_1, O_MD, 2'd1);
        applyStimulus(I_MD, O_MD, 2'd2);
        applyStimulus(I_MD, O_MD, 2'd2);
        applyStimulus(I_MD, O_DONE, 2'd2);
        applyStimulus(I_IDLE, O_DEF, 2'd0);

        // 5: imem miss, then imem miss with a taken branch
        applyStimulus(7'b0_0_0_0_0_1_0, O_IMEM, 2'd0);
        applyStimulus(7'b0_0_1_0_0_1_0, O_FLUSH, 2'd0);
        applyStimulus(I_IDLE, O_DEF, 2'd0);

        // 6a: long stall saturates the 3-bit stall counter at 7
        for (int i = 0; i < 10; i++) applyStimulus(I_STALL, O_STALL, 2'd0);
        applyStimulus(I_IDLE, O_DEF, 2'd0);
        applyStimulus(I_IDLE, O_DEF, 2'd0);

        // 6b: reset mid MD_WAIT aborts with no md_done
        applyStimulus(I_MD, O_MD, 2'd0);
        applyStimulus(I_MD, O_MD, 2'd2);
        applyStimulus(7'b1_0_0_1_0_1_1, O_RST, 2'd2);
        applyStimulus(I_IDLE, O_DEF, 2'd0);
        applyStimulus(I_IDLE, O_DEF, 2'd0);
        applyStimulus(I_IDLE, O_DEF, 2'd0);

        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drain", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
